// File: rtl/dmem_arb_pkg.sv
// Shared types and Funct3 encodings for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_CORE = 2'd1,
        RESP_DMA  = 2'd2
    } resp_owner_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/dmem_starve_ctr.sv
// DMA starvation guard: counts consecutive denied DMA cycles and forces a DMA
// grant once the count reaches STARVE_LIMIT. Built only with DMEM_ARB_STARVE_EN.
module dmem_starve_ctr #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic dma_req_i,
    input  logic dma_gnt_i,
    output logic force_dma_o
);

    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    logic [3:0] wait_cnt_q;
    logic [3:0] wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!dma_req_i || dma_gnt_i) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q != LIMIT_C) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= 4'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign force_dma_o = (wait_cnt_q == LIMIT_C) && dma_req_i;

endmodule

// File: rtl/dmem_arbiter.sv
// Fixed-priority arbiter for the data memory port (core over DMA) with a
// registered read-response path. Define DMEM_ARB_STARVE_EN for the DMA starvation guard.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DM_ADDRESS   = 9,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [DM_ADDRESS-1:0] core_addr,
    input  logic [DATA_W-1:0]     core_wdata,
    input  logic [2:0]            core_funct3,
    output logic                  core_gnt,
    output logic                  core_rvalid,
    output logic [DATA_W-1:0]     core_rdata,

    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [DM_ADDRESS-1:0] dma_addr,
    input  logic [DATA_W-1:0]     dma_wdata,
    input  logic [2:0]            dma_funct3,
    output logic                  dma_gnt,
    output logic                  dma_rvalid,
    output logic [DATA_W-1:0]     dma_rdata,

    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [DM_ADDRESS-1:0] a,
    output logic [DATA_W-1:0]     wd,
    output logic [2:0]            Funct3,
    input  logic [DATA_W-1:0]     rd
);

    logic force_dma;

`ifdef DMEM_ARB_STARVE_EN
    dmem_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .clk        (clk),
        .reset      (reset),
        .dma_req_i  (dma_req),
        .dma_gnt_i  (dma_gnt),
        .force_dma_o(force_dma)
    );
`else
    logic unused_starve_limit;
    assign unused_starve_limit = (STARVE_LIMIT == 0);
    assign force_dma           = 1'b0;
`endif

    assign core_gnt = core_req && !force_dma;
    assign dma_gnt  = dma_req && !core_gnt;

    assign MemRead  = (core_gnt && !core_we) || (dma_gnt && !dma_we);
    assign MemWrite = (core_gnt && core_we) || (dma_gnt && dma_we);

    // With no grant the core fields pass through; MemRead/MemWrite are low so they are inert.
    assign a      = dma_gnt ? dma_addr   : core_addr;
    assign wd     = dma_gnt ? dma_wdata  : core_wdata;
    assign Funct3 = dma_gnt ? dma_funct3 : core_funct3;

    resp_owner_e       state_q, state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = RESP_NONE;
        rdata_d = rdata_q;
        if (core_gnt && !core_we) begin
            state_d = RESP_CORE;
            rdata_d = rd;
        end else if (dma_gnt && !dma_we) begin
            state_d = RESP_DMA;
            rdata_d = rd;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RESP_NONE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    assign core_rvalid = (state_q == RESP_CORE);
    assign dma_rvalid  = (state_q == RESP_DMA);
    assign core_rdata  = rdata_q;
    assign dma_rdata   = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random
// traffic, all checked against a transaction-level reference model.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int LIMIT = 4;
`ifdef DMEM_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          core_req, core_we, dma_req, dma_we;
    logic [AW-1:0] core_addr, dma_addr, a;
    logic [DW-1:0] core_wdata, dma_wdata, wd, rd;
    logic [2:0]    core_funct3, dma_funct3, Funct3;
    logic          core_gnt, core_rvalid, dma_gnt, dma_rvalid, MemRead, MemWrite;
    logic [DW-1:0] core_rdata, dma_rdata;

    dmem_arbiter #(
        .DM_ADDRESS  (AW),
        .DATA_W      (DW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_funct3(core_funct3),
        .core_gnt   (core_gnt),
        .core_rvalid(core_rvalid),
        .core_rdata (core_rdata),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_funct3 (dma_funct3),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .a          (a),
        .wd         (wd),
        .Funct3     (Funct3),
        .rd         (rd)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: who owns the pending response, the data it carries,
    // and how many cycles in a row the DMA has been kept waiting.
    int          m_owner  = 0;   // 0 none, 1 core, 2 dma
    logic [31:0] m_rdata  = '0;
    int          m_streak = 0;
    logic        last_cg  = 1'b0;
    logic        last_dg  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic core_drive(input logic req, input logic we, input logic [AW-1:0] ad,
                              input logic [DW-1:0] wdat, input logic [2:0] f3);
        core_req = req; core_we = we; core_addr = ad; core_wdata = wdat; core_funct3 = f3;
    endtask

    task automatic dma_drive(input logic req, input logic we, input logic [AW-1:0] ad,
                             input logic [DW-1:0] wdat, input logic [2:0] f3);
        dma_req = req; dma_we = we; dma_addr = ad; dma_wdata = wdat; dma_funct3 = f3;
    endtask

    task automatic idle();
        core_drive(1'b0, 1'b0, '0, '0, 3'b000);
        dma_drive(1'b0, 1'b0, '0, '0, 3'b000);
    endtask

    // Called just after a rising edge with inputs already applied: checks the
    // cycle at the falling edge, then advances the model across the next edge.
    task automatic step();
        logic frc, cg, dg;
        @(negedge clk);
        frc = STARVE_EN && dma_req && (m_streak >= LIMIT);
        cg  = core_req && !frc;
        dg  = dma_req && !cg;
        check("core_gnt", {31'b0, core_gnt}, {31'b0, cg});
        check("dma_gnt",  {31'b0, dma_gnt},  {31'b0, dg});
        check("MemRead",  {31'b0, MemRead},  {31'b0, (cg && !core_we) || (dg && !dma_we)});
        check("MemWrite", {31'b0, MemWrite}, {31'b0, (cg && core_we) || (dg && dma_we)});
        if (cg) begin
            check("a_core",  32'(a),      32'(core_addr));
            check("wd_core", wd,          core_wdata);
            check("f3_core", 32'(Funct3), 32'(core_funct3));
        end else if (dg) begin
            check("a_dma",  32'(a),      32'(dma_addr));
            check("wd_dma", wd,          dma_wdata);
            check("f3_dma", 32'(Funct3), 32'(dma_funct3));
        end
        check("core_rvalid", {31'b0, core_rvalid}, {31'b0, m_owner == 1});
        check("dma_rvalid",  {31'b0, dma_rvalid},  {31'b0, m_owner == 2});
        if (m_owner == 1) check("core_rdata", core_rdata, m_rdata);
        if (m_owner == 2) check("dma_rdata",  dma_rdata,  m_rdata);
        last_cg = cg;
        last_dg = dg;
        @(posedge clk);
        if (reset) begin
            m_owner = 0; m_rdata = '0; m_streak = 0;
        end else begin
            if (cg && !core_we) begin
                m_owner = 1; m_rdata = rd;
            end else if (dg && !dma_we) begin
                m_owner = 2; m_rdata = rd;
            end else begin
                m_owner = 0;
            end
            if (!dma_req || dg)        m_streak = 0;
            else if (m_streak < LIMIT) m_streak++;
        end
        #1;
    endtask

    initial begin
        reset = 1'b1;
        rd    = '0;
        idle();
        #12;
        check("rst_core_rvalid", {31'b0, core_rvalid}, 32'd0);
        check("rst_dma_rvalid",  {31'b0, dma_rvalid},  32'd0);
        check("rst_core_rdata",  core_rdata,           32'd0);
        check("rst_dma_rdata",   dma_rdata,            32'd0);
        check("rst_MemRead",     {31'b0, MemRead},     32'd0);
        check("rst_MemWrite",    {31'b0, MemWrite},    32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Core-only load
        core_drive(1'b1, 1'b0, 9'h010, '0, F3_LW);
        rd = 32'hDEADBEEF;
        step();
        idle(); rd = '0;
        step();

        // Contention: core load vs DMA store, DMA wins the following cycle
        core_drive(1'b1, 1'b0, 9'h004, '0, F3_LW);
        dma_drive(1'b1, 1'b1, 9'h008, 32'h1234_5678, F3_SW);
        rd = 32'h0BAD_F00D;
        step();
        core_req = 1'b0;
        step();
        idle();
        step();

        // Back-to-back loads, core then DMA
        core_drive(1'b1, 1'b0, 9'h020, '0, F3_LW);
        rd = 32'h11;
        step();
        core_req = 1'b0;
        dma_drive(1'b1, 1'b0, 9'h024, '0, F3_LW);
        rd = 32'h22;
        step();
        idle(); rd = '0;
        step();
        step();

        // Store-only traffic
        core_drive(1'b1, 1'b1, 9'h003, 32'hAB, F3_SB);
        step();
        idle();
        step();

        // Continuous contention: exercises the starvation guard (or strict priority)
        core_drive(1'b1, 1'b0, 9'h040, '0, F3_LW);
        dma_drive(1'b1, 1'b1, 9'h044, 32'hCAFE_0001, F3_SW);
        for (int i = 0; i < 6; i++) begin
            rd = 32'(i + 1);
            step();
        end
        dma_drive(1'b1, 1'b1, 9'h048, 32'hCAFE_0002, F3_SW);
        for (int i = 0; i < 6; i++) begin
            rd = 32'(i + 100);
            step();
        end
        idle();
        step();

        // Reset mid-load: pending response and captured data must vanish at once
        core_drive(1'b1, 1'b0, 9'h050, '0, F3_LW);
        rd = 32'h55;
        step();
        rd = 32'h66;
        @(negedge clk);
        check("mid_core_gnt",    {31'b0, core_gnt},    32'd1);
        check("mid_core_rvalid", {31'b0, core_rvalid}, 32'd1);
        check("mid_core_rdata",  core_rdata,           32'h55);
        #1;
        reset = 1'b1;
        core_req = 1'b0;
        #1;
        check("async_core_rvalid", {31'b0, core_rvalid}, 32'd0);
        check("async_core_rdata",  core_rdata,           32'd0);
        @(posedge clk); #1;
        check("rst_hold_core_rvalid", {31'b0, core_rvalid}, 32'd0);
        check("rst_hold_dma_rvalid",  {31'b0, dma_rvalid},  32'd0);
        check("rst_hold_rdata",       core_rdata,           32'd0);
        m_owner = 0; m_rdata = '0; m_streak = 0;
        last_cg = 1'b0; last_dg = 1'b0;
        reset = 1'b0;
        idle();
        step();

        // Random traffic; a denied requester keeps its fields stable
        for (int i = 0; i < 400; i++) begin
            if (!(core_req && !last_cg)) begin
                core_drive(($urandom % 100) < 60, 1'($urandom), 9'($urandom), $urandom, 3'($urandom));
            end
            if (!(dma_req && !last_dg)) begin
                dma_drive(($urandom % 100) < 50, 1'($urandom), 9'($urandom), $urandom, 3'($urandom));
            end
            rd = $urandom;
            step();
        end
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
